// File: rtl/warp_register_file.sv
// Banked per-thread register file: one masked warp-wide write port, two registered warp-wide read ports,
// and an init FSM that loads threadIdx/blockIdx/blockDim. Define RF_WRITE_BYPASS_EN for write-first reads.
module warp_register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_WARPS  = 4,
    parameter int WARP_SIZE  = 8,
    parameter int NUM_REGS   = 16,
    localparam int WW = $clog2(NUM_WARPS),
    localparam int RW = $clog2(NUM_REGS),
    localparam int LW = WARP_SIZE * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  block_start,
    input  logic [DATA_WIDTH-1:0] block_idx,
    input  logic [DATA_WIDTH-1:0] block_dim,
    output logic                  ready,
    input  logic                  wr_en,
    input  logic [WW-1:0]         wr_warp,
    input  logic [RW-1:0]         wr_addr,
    input  logic [WARP_SIZE-1:0]  wr_mask,
    input  logic [LW-1:0]         wr_data,
    input  logic                  rd_en,
    input  logic [WW-1:0]         rd_warp,
    input  logic [RW-1:0]         rd_addr_a,
    input  logic [RW-1:0]         rd_addr_b,
    output logic                  rd_valid,
    output logic [LW-1:0]         rd_data_a,
    output logic [LW-1:0]         rd_data_b,
    output logic                  wr_ro_err
);

    localparam int RO_BASE = NUM_REGS - 3;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                state_reg, state_next;
    logic [WW-1:0]         warp_cnt_reg, warp_cnt_next;
    logic                  latch_pending_reg, latch_pending_next;
    logic [DATA_WIDTH-1:0] shadow_idx_reg, shadow_idx_next;
    logic [DATA_WIDTH-1:0] shadow_dim_reg, shadow_dim_next;
    logic                  init_we;
    logic [DATA_WIDTH-1:0] init_idx, init_dim;

    logic                  wr_accept, wr_reject;
    logic [LW-1:0]         wr_old, wr_merged;
    logic [LW-1:0]         tid_row, idx_row, dim_row;
    logic [LW-1:0]         rd_word_a, rd_word_b, rd_next_a, rd_next_b;
    logic [LW-1:0]         rows [NUM_WARPS][NUM_REGS];

    logic                  rd_valid_reg;
    logic [LW-1:0]         rd_data_a_reg, rd_data_b_reg;
    logic                  wr_ro_err_reg;

    assign ready = (state_reg == ST_READY);

    // After reset release the shadow values have not been captured yet, so warp 0 takes them straight
    // from the inputs on the same edge that latches them.
    assign init_idx = latch_pending_reg ? block_idx : shadow_idx_reg;
    assign init_dim = latch_pending_reg ? block_dim : shadow_dim_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= ST_INIT;
            warp_cnt_reg      <= '0;
            latch_pending_reg <= 1'b1;
            shadow_idx_reg    <= '0;
            shadow_dim_reg    <= '0;
        end else begin
            state_reg         <= state_next;
            warp_cnt_reg      <= warp_cnt_next;
            latch_pending_reg <= latch_pending_next;
            shadow_idx_reg    <= shadow_idx_next;
            shadow_dim_reg    <= shadow_dim_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        warp_cnt_next      = warp_cnt_reg;
        latch_pending_next = latch_pending_reg;
        shadow_idx_next    = shadow_idx_reg;
        shadow_dim_next    = shadow_dim_reg;
        init_we            = 1'b0;
        case (state_reg)
            ST_INIT: begin
                if (block_start) begin
                    warp_cnt_next      = '0;
                    latch_pending_next = 1'b0;
                    shadow_idx_next    = block_idx;
                    shadow_dim_next    = block_dim;
                end else begin
                    init_we            = 1'b1;
                    latch_pending_next = 1'b0;
                    shadow_idx_next    = init_idx;
                    shadow_dim_next    = init_dim;
                    if (warp_cnt_reg == WW'(NUM_WARPS - 1)) begin
                        warp_cnt_next = '0;
                        state_next    = ST_READY;
                    end else begin
                        warp_cnt_next = warp_cnt_reg + 1'b1;
                    end
                end
            end
            ST_READY: begin
                if (block_start) begin
                    state_next      = ST_INIT;
                    warp_cnt_next   = '0;
                    shadow_idx_next = block_idx;
                    shadow_dim_next = block_dim;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign wr_accept = ready && wr_en && (wr_addr <  RW'(RO_BASE));
    assign wr_reject = ready && wr_en && (wr_addr >= RW'(RO_BASE));
    assign wr_old    = rows[wr_warp][wr_addr];
    assign rd_word_a = rows[rd_warp][rd_addr_a];
    assign rd_word_b = rows[rd_warp][rd_addr_b];

    generate
        for (genvar gi = 0; gi < WARP_SIZE; gi++) begin : g_lane
            assign tid_row[gi*DATA_WIDTH +: DATA_WIDTH] =
                DATA_WIDTH'(warp_cnt_reg) * DATA_WIDTH'(WARP_SIZE) + DATA_WIDTH'(gi);
            assign idx_row[gi*DATA_WIDTH +: DATA_WIDTH] = init_idx;
            assign dim_row[gi*DATA_WIDTH +: DATA_WIDTH] = init_dim;
            assign wr_merged[gi*DATA_WIDTH +: DATA_WIDTH] = wr_mask[gi] ?
                wr_data[gi*DATA_WIDTH +: DATA_WIDTH] : wr_old[gi*DATA_WIDTH +: DATA_WIDTH];
`ifdef RF_WRITE_BYPASS_EN
            // Write-first: a masked lane being written this cycle forwards the incoming value.
            assign rd_next_a[gi*DATA_WIDTH +: DATA_WIDTH] =
                (wr_accept && wr_mask[gi] && wr_warp == rd_warp && wr_addr == rd_addr_a) ?
                wr_data[gi*DATA_WIDTH +: DATA_WIDTH] : rd_word_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign rd_next_b[gi*DATA_WIDTH +: DATA_WIDTH] =
                (wr_accept && wr_mask[gi] && wr_warp == rd_warp && wr_addr == rd_addr_b) ?
                wr_data[gi*DATA_WIDTH +: DATA_WIDTH] : rd_word_b[gi*DATA_WIDTH +: DATA_WIDTH];
`else
            assign rd_next_a[gi*DATA_WIDTH +: DATA_WIDTH] = rd_word_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign rd_next_b[gi*DATA_WIDTH +: DATA_WIDTH] = rd_word_b[gi*DATA_WIDTH +: DATA_WIDTH];
`endif
        end

        for (genvar gw = 0; gw < NUM_WARPS; gw++) begin : g_warp
            for (genvar gr = 0; gr < NUM_REGS; gr++) begin : g_reg
                logic [LW-1:0] entry_reg;
                logic [LW-1:0] init_val;

                if (gr == NUM_REGS - 3) begin : g_tid
                    assign init_val = tid_row;
                end else if (gr == NUM_REGS - 2) begin : g_bidx
                    assign init_val = idx_row;
                end else if (gr == NUM_REGS - 1) begin : g_bdim
                    assign init_val = dim_row;
                end else begin : g_gpr
                    assign init_val = '0;
                end

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        entry_reg <= '0;
                    end else if (init_we && warp_cnt_reg == WW'(gw)) begin
                        entry_reg <= init_val;
                    end else if (wr_accept && wr_warp == WW'(gw) && wr_addr == RW'(gr)) begin
                        entry_reg <= wr_merged;
                    end
                end

                assign rows[gw][gr] = entry_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_reg  <= 1'b0;
            rd_data_a_reg <= '0;
            rd_data_b_reg <= '0;
            wr_ro_err_reg <= 1'b0;
        end else begin
            rd_valid_reg  <= ready && rd_en;
            wr_ro_err_reg <= wr_reject;
            if (ready && rd_en) begin
                rd_data_a_reg <= rd_next_a;
                rd_data_b_reg <= rd_next_b;
            end
        end
    end

    assign rd_valid  = rd_valid_reg;
    assign rd_data_a = rd_data_a_reg;
    assign rd_data_b = rd_data_b_reg;
    assign wr_ro_err = wr_ro_err_reg;

endmodule

// File: tb/tb_warp_register_file.sv
// Directed bench for warp_register_file: init sequence, masked writes, read-only rejection,
// same-cycle bypass behaviour, block relaunch and asynchronous reset.
module tb_warp_register_file;

    localparam int DW = 16;
    localparam int WS = 8;
    localparam int LW = DW * WS;

    logic          clk = 1'b0;
    logic          reset;
    logic          block_start;
    logic [DW-1:0] block_idx, block_dim;
    logic          ready;
    logic          wr_en;
    logic [1:0]    wr_warp;
    logic [3:0]    wr_addr;
    logic [WS-1:0] wr_mask;
    logic [LW-1:0] wr_data;
    logic          rd_en;
    logic [1:0]    rd_warp;
    logic [3:0]    rd_addr_a, rd_addr_b;
    logic          rd_valid;
    logic [LW-1:0] rd_data_a, rd_data_b;
    logic          wr_ro_err;

    int checks = 0;
    int errors = 0;

    warp_register_file dut (
        .clk(clk), .reset(reset), .block_start(block_start), .block_idx(block_idx),
        .block_dim(block_dim), .ready(ready), .wr_en(wr_en), .wr_warp(wr_warp),
        .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data), .rd_en(rd_en),
        .rd_warp(rd_warp), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_ro_err(wr_ro_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    // Lane i holds base+i.
    function automatic logic [LW-1:0] seq(input logic [DW-1:0] base);
        logic [LW-1:0] v;
        for (int i = 0; i < WS; i++) v[i*DW +: DW] = base + DW'(i);
        return v;
    endfunction

    function automatic logic [LW-1:0] rep(input logic [DW-1:0] x);
        return {WS{x}};
    endfunction

    // Lanes with mask bit set take a, others take b.
    function automatic logic [LW-1:0] pick(input logic [WS-1:0] m, input logic [LW-1:0] a,
                                           input logic [LW-1:0] b);
        logic [LW-1:0] v;
        for (int i = 0; i < WS; i++) v[i*DW +: DW] = m[i] ? a[i*DW +: DW] : b[i*DW +: DW];
        return v;
    endfunction

    task automatic do_read(input logic [1:0] w, input logic [3:0] a, input logic [3:0] b);
        rd_en = 1'b1; rd_warp = w; rd_addr_a = a; rd_addr_b = b;
        step();
        rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] w, input logic [3:0] a, input logic [WS-1:0] m,
                            input logic [LW-1:0] d);
        wr_en = 1'b1; wr_warp = w; wr_addr = a; wr_mask = m; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic check_init_window(input string tag);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk(tag, LW'(ready), LW'(k == 4));
        end
    endtask

    initial begin
        logic [LW-1:0] exp_rd;
        reset = 1'b1; block_start = 1'b0; block_idx = 16'd2; block_dim = 16'd32;
        wr_en = 1'b0; wr_warp = '0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        rd_en = 1'b0; rd_warp = '0; rd_addr_a = '0; rd_addr_b = '0;
        step(); step();
        chk("rst_ready", LW'(ready), '0);
        chk("rst_rd_valid", LW'(rd_valid), '0);
        chk("rst_ro_err", LW'(wr_ro_err), '0);
        chk("rst_rd_data_a", rd_data_a, '0);

        reset = 1'b0;
        check_init_window("init_ready");

        do_read(2'd1, 4'd13, 4'd15);
        chk("rd_valid_1", LW'(rd_valid), LW'(1));
        chk("tid_w1", rd_data_a, seq(16'd8));
        chk("bdim_w1", rd_data_b, rep(16'd32));
        step();
        chk("rd_valid_0", LW'(rd_valid), '0);
        chk("rd_hold", rd_data_a, seq(16'd8));

        do_write(2'd3, 4'd5, 8'hA5, seq(16'h0100));
        chk("gpr_ro_err", LW'(wr_ro_err), '0);
        do_read(2'd3, 4'd5, 4'd6);
        chk("masked_wr", rd_data_a, pick(8'hA5, seq(16'h0100), '0));
        chk("other_gpr", rd_data_b, '0);

        do_write(2'd0, 4'd14, 8'hFF, rep(16'hFFFF));
        chk("ro_err_pulse", LW'(wr_ro_err), LW'(1));
        step();
        chk("ro_err_clear", LW'(wr_ro_err), '0);
        do_read(2'd0, 4'd14, 4'd13);
        chk("bidx_kept", rd_data_a, rep(16'd2));
        chk("tid_w0", rd_data_b, seq(16'd0));

        do_write(2'd2, 4'd1, 8'hFF, seq(16'h2000));
        wr_en = 1'b1; wr_warp = 2'd2; wr_addr = 4'd1; wr_mask = 8'hFF; wr_data = seq(16'h3000);
        do_read(2'd2, 4'd1, 4'd1);
        wr_en = 1'b0;
`ifdef RF_WRITE_BYPASS_EN
        exp_rd = seq(16'h3000);
`else
        exp_rd = seq(16'h2000);
`endif
        chk("same_cycle_full", rd_data_a, exp_rd);
        wr_en = 1'b1; wr_warp = 2'd2; wr_addr = 4'd1; wr_mask = 8'h0F; wr_data = seq(16'h4000);
        do_read(2'd2, 4'd1, 4'd0);
        wr_en = 1'b0;
`ifdef RF_WRITE_BYPASS_EN
        exp_rd = pick(8'h0F, seq(16'h4000), seq(16'h3000));
`else
        exp_rd = seq(16'h3000);
`endif
        chk("same_cycle_part", rd_data_a, exp_rd);
        do_read(2'd2, 4'd1, 4'd0);
        chk("after_write", rd_data_a, pick(8'h0F, seq(16'h4000), seq(16'h3000)));

        // Relaunch with a new blockIdx: GPRs cleared, read-only regs reloaded.
        block_start = 1'b1; block_idx = 16'd3;
        step();
        block_start = 1'b0;
        chk("bs_ready", LW'(ready), '0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("bs_init_ready", LW'(ready), LW'(k == 4));
        end
        do_read(2'd3, 4'd5, 4'd14);
        chk("gpr_cleared", rd_data_a, '0);
        chk("bidx_new", rd_data_b, rep(16'd3));
        do_read(2'd2, 4'd1, 4'd15);
        chk("gpr2_cleared", rd_data_a, '0);
        chk("bdim_w2", rd_data_b, rep(16'd32));

        // Asynchronous reset landing during a read.
        rd_en = 1'b1; rd_warp = 2'd1; rd_addr_a = 4'd13; rd_addr_b = 4'd14;
        step();
        chk("pre_rst_valid", LW'(rd_valid), LW'(1));
        reset = 1'b1;
        #1;
        rd_en = 1'b0;
        chk("rst_rd_valid", LW'(rd_valid), '0);
        chk("rst_rd_ready", LW'(ready), '0);
        chk("rst_rd_data", rd_data_a, '0);

        // Reset again partway through INIT, then a full INIT with new values.
        block_idx = 16'd5;
        step();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        #1;
        chk("rst_init_ready", LW'(ready), '0);
        block_idx = 16'd7; block_dim = 16'd64;
        step();
        reset = 1'b0;
        check_init_window("reinit_ready");
        do_read(2'd2, 4'd14, 4'd13);
        chk("bidx_reinit", rd_data_a, rep(16'd7));
        chk("tid_w2", rd_data_b, seq(16'd16));
        do_read(2'd3, 4'd15, 4'd5);
        chk("bdim_reinit", rd_data_a, rep(16'd64));
        chk("gpr_reinit", rd_data_b, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
